// File: rtl/seg7_scan_controller_pkg.sv
// Shared seven-segment character constants and display-mode type.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_scan_controller_pkg;

  localparam logic [6:0] CHAR_ZERO  = 7'h40;
  localparam logic [6:0] CHAR_ONE   = 7'h79;
  localparam logic [6:0] CHAR_TWO   = 7'h24;
  localparam logic [6:0] CHAR_THREE = 7'h30;
  localparam logic [6:0] CHAR_FOUR  = 7'h19;
  localparam logic [6:0] CHAR_FIVE  = 7'h12;
  localparam logic [6:0] CHAR_SIX   = 7'h02;
  localparam logic [6:0] CHAR_SEVEN = 7'h78;
  localparam logic [6:0] CHAR_EIGHT = 7'h00;
  localparam logic [6:0] CHAR_NINE  = 7'h10;
  localparam logic [6:0] CHAR_A     = 7'h08;
  localparam logic [6:0] CHAR_B     = 7'h03;
  localparam logic [6:0] CHAR_C     = 7'h46;
  localparam logic [6:0] CHAR_D     = 7'h21;
  localparam logic [6:0] CHAR_E     = 7'h06;
  localparam logic [6:0] CHAR_F     = 7'h0E;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

  typedef enum logic {
    ModeHex    = 1'b0,
    ModeOpcode = 1'b1
  } disp_mode_e;

endpackage

// File: rtl/seg7_scan_controller_if.sv
// Display-update valid/ready channel between the requester and the scan controller.
interface seg7_scan_controller_if;
  logic        upd_valid;
  logic        upd_ready;
  logic        upd_mode;
  logic [15:0] upd_value;

  modport master (
    output upd_valid,
    output upd_mode,
    output upd_value,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_mode,
    input  upd_value,
    output upd_ready
  );
endinterface

// File: rtl/seg7_slot_timer.sv
// Digit-slot timer: cycles per slot, slot index and the anti-ghosting blank window.
module seg7_slot_timer
  import seg7_scan_controller_pkg::*;
#(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [DIGIT_W-1:0] idx,
  output logic               tick,
  output logic               blank
);

  localparam int unsigned CW = $clog2(PRESCALE);

  logic [CW-1:0]      cnt_q;
  logic [DIGIT_W-1:0] idx_q;

  assign tick  = (cnt_q == CW'(PRESCALE - 1));
  assign blank = (cnt_q < CW'(BLANK_CYCLES));
  assign idx   = idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      idx_q <= idx_q + DIGIT_W'(1);
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed seven-segment driver with frame-aligned content updates.
// Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 4
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 250
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         disp_en,
  seg7_scan_controller_if.slave        upd,
  output logic [3:0]                   opcode_sel,
  input  logic [27:0]                  opcode_glyphs,
  output logic [6:0]                   seg,
  output logic [3:0]                   an,
  output logic                         frame_done
`ifdef SEG7_BLINK_EN
  ,
  input  logic [3:0]                   blink_mask
`endif
);

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = CHAR_ZERO;
      4'h1: g = CHAR_ONE;
      4'h2: g = CHAR_TWO;
      4'h3: g = CHAR_THREE;
      4'h4: g = CHAR_FOUR;
      4'h5: g = CHAR_FIVE;
      4'h6: g = CHAR_SIX;
      4'h7: g = CHAR_SEVEN;
      4'h8: g = CHAR_EIGHT;
      4'h9: g = CHAR_NINE;
      4'hA: g = CHAR_A;
      4'hB: g = CHAR_B;
      4'hC: g = CHAR_C;
      4'hD: g = CHAR_D;
      4'hE: g = CHAR_E;
      default: g = CHAR_F;
    endcase
    return g;
  endfunction

  logic [DIGIT_W-1:0] idx;
  logic               tick;
  logic               blank;
  logic               frame_end;
  logic               blink_off;

  logic               pending_q;
  disp_mode_e         pend_mode_q;
  logic [15:0]        pend_value_q;
  disp_mode_e         act_mode_q;
  logic [15:0]        act_value_q;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               frame_done_q;
  logic [3:0]         nibble;
  logic [6:0]         glyph;

  seg7_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk   (clk),
    .reset (reset),
    .idx   (idx),
    .tick  (tick),
    .blank (blank)
  );

  assign frame_end     = tick && (idx == DIGIT_W'(NUM_DIGITS - 1));
  assign upd.upd_ready = ~pending_q;
  assign opcode_sel    = act_value_q[3:0];
  assign seg           = seg_q;
  assign an            = an_q;
  assign frame_done    = frame_done_q;

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt_q;
  logic          blink_phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_done_q) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  assign blink_off = blink_phase_q && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    an_d   = AN_OFF;
    seg_d  = SEG_BLANK;
    nibble = 4'h0;
    glyph  = SEG_BLANK;
    if (!blank && disp_en) an_d = ~(4'b1000 >> idx);
    // idx 0 is the leftmost digit: MS nibble and MS glyph field.
    unique case (idx)
      2'd0: begin nibble = act_value_q[15:12]; glyph = opcode_glyphs[27:21]; end
      2'd1: begin nibble = act_value_q[11:8];  glyph = opcode_glyphs[20:14]; end
      2'd2: begin nibble = act_value_q[7:4];   glyph = opcode_glyphs[13:7];  end
      2'd3: begin nibble = act_value_q[3:0];   glyph = opcode_glyphs[6:0];   end
      default: ;
    endcase
    seg_d = (act_mode_q == ModeHex) ? hex_glyph(nibble) : glyph;
    if (blink_off) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 1'b0;
      pend_mode_q  <= ModeHex;
      pend_value_q <= '0;
      act_mode_q   <= ModeHex;
      act_value_q  <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_end;
      // Apply only at frame end so a frame is never torn; capture is blocked while pending.
      if (frame_end && pending_q) begin
        act_mode_q  <= pend_mode_q;
        act_value_q <= pend_value_q;
        pending_q   <= 1'b0;
      end else if (upd.upd_valid && !pending_q) begin
        pend_mode_q  <= disp_mode_e'(upd.upd_mode);
        pend_value_q <= upd.upd_value;
        pending_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized bench for seg7_scan_controller against a frame-level reference model.
module tb_seg7_scan_controller;

  localparam int unsigned P     = 8;
  localparam int unsigned BL    = 2;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_en;
  logic [3:0]  opcode_sel;
  logic [27:0] opcode_glyphs;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic [3:0]  blink_mask;

  seg7_scan_controller_if upd_if ();

  seg7_scan_controller #(
    .PRESCALE     (P),
    .BLANK_CYCLES (BL)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .disp_en       (disp_en),
    .upd           (upd_if),
    .opcode_sel    (opcode_sel),
    .opcode_glyphs (opcode_glyphs),
    .seg           (seg),
    .an            (an),
    .frame_done    (frame_done)
`ifdef SEG7_BLINK_EN
    ,
    .blink_mask    (blink_mask)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Stand-in mnemonic decoder: opcode A spells "Add ".
  function automatic logic [27:0] mnem(input logic [3:0] op);
    if (op == 4'hA) return {hex_tab[10], hex_tab[13], hex_tab[13], 7'h7F};
    return {hex_tab[op], hex_tab[op ^ 4'h5], hex_tab[~op], hex_tab[op + 4'h3]};
  endfunction

  assign opcode_glyphs = mnem(opcode_sel);

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned t;

  logic        m_act_mode;
  logic [15:0] m_act_val;
  logic        m_pend;
  logic        m_pmode;
  logic [15:0] m_pval;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_clear();
    t          = 0;
    m_act_mode = 1'b0;
    m_act_val  = '0;
    m_pend     = 1'b0;
    m_pmode    = 1'b0;
    m_pval     = '0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    upd_if.upd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_ready", 32'(upd_if.upd_ready), 32'h1);
    check("rst_opcode_sel", 32'(opcode_sel), 32'h0);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: predict outputs for edge t, clock it, compare, then drive next inputs.
  task automatic step();
    int unsigned cnt, idx, nfd;
    logic        fend, xfer, phase;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    cnt  = t % P;
    idx  = (t / P) % 4;
    fend = (t % FRAME) == FRAME - 1;
    exp_an = (disp_en && cnt >= BL) ? (4'hF & ~(4'b0001 << (3 - idx))) : 4'hF;
    if (m_act_mode) exp_seg = 7'(mnem(m_act_val[3:0]) >> (7 * (3 - idx)));
    else            exp_seg = hex_tab[4'((m_act_val >> (4 * (3 - idx))) & 16'hF)];
    nfd   = (t >= 1) ? (t - 1) / FRAME : 0;
    phase = ((nfd / BF) % 2) == 1;
`ifdef SEG7_BLINK_EN
    if (phase && blink_mask[idx]) exp_seg = 7'h7F;
`endif
    xfer = upd_if.upd_valid && !m_pend;
    if (fend && m_pend) begin
      m_act_mode = m_pmode;
      m_act_val  = m_pval;
      m_pend     = 1'b0;
    end else if (xfer) begin
      m_pmode = upd_if.upd_mode;
      m_pval  = upd_if.upd_value;
      m_pend  = 1'b1;
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(fend));
    check("upd_ready", 32'(upd_if.upd_ready), 32'(!m_pend));
    check("opcode_sel", 32'(opcode_sel), 32'(m_act_val[3:0]));
    t++;
    if (xfer) upd_if.upd_valid = 1'b0;
    if (t % FRAME == 0) begin
      disp_en    = ($urandom_range(0, 3) != 0);
      blink_mask = 4'($urandom_range(0, 15));
    end
    // Requester may raise valid even while busy; it then holds until accepted.
    if (!upd_if.upd_valid &&
        (($urandom_range(0, 39) == 0) ||
         ((t % FRAME == FRAME - 1) && !m_pend && $urandom_range(0, 1) == 0))) begin
      upd_if.upd_valid = 1'b1;
      upd_if.upd_mode  = 1'($urandom_range(0, 1));
      upd_if.upd_value = 16'($urandom);
    end
  endtask

  initial begin
    reset            = 1'b1;
    disp_en          = 1'b1;
    blink_mask       = 4'b0001;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_mode  = 1'b0;
    upd_if.upd_value = '0;
    model_clear();
    @(posedge clk);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        upd_if.upd_valid = 1'b1;
        upd_if.upd_mode  = 1'b0;
        upd_if.upd_value = 16'h12AF;
        for (int k = 0; k < 64 && !m_pend; k++) step();
        do_reset();
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
